// File: rtl/interleave_merger_if.sv
// interleave_merger_if: lane inputs and merged output of interleave_merger
// slave = merger side, master = source/sink side.
// Signals: in_data/in_valid/in_ready per lane, out_data/out_lane/out_valid/out_ready, clear, lane_sel
interface interleave_merger_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_LANES    = 4,
  parameter int LB_NUM_LANES = $clog2(NUM_LANES)
);
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_LANES-1:0]                 in_valid;
  logic [NUM_LANES-1:0]                 in_ready;
  logic [DATA_WIDTH-1:0]                out_data;
  logic [LB_NUM_LANES-1:0]              out_lane;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 clear;
  logic [LB_NUM_LANES-1:0]              lane_sel;
  modport slave (
    input  in_data, in_valid, out_ready, clear,
    output in_ready, out_data, out_lane, out_valid, lane_sel
  );
  modport master (
    output in_data, in_valid, out_ready, clear,
    input  in_ready, out_data, out_lane, out_valid, lane_sel
  );
endinterface

// File: rtl/interleave_merger.sv
// interleave_merger: strict round-robin merge of NUM_LANES valid/ready lanes into one registered stream
// Ports: clk, rstn (async active-low), bus (interleave_merger_if.slave: lane inputs, merged output, clear, lane_sel).
// Option: INTERLEAVE_MERGER_SKID_EN turns the output register into a 2-entry skid buffer so in_ready is registered.
module interleave_merger #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_LANES    = 4,
  parameter int LB_NUM_LANES = $clog2(NUM_LANES)
) (
  input logic clk,
  input logic rstn,
  interleave_merger_if.slave bus
);
  logic [LB_NUM_LANES-1:0] sel_r, sel_nxt;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [LB_NUM_LANES-1:0] lane_r;
  logic                    valid_r, can_accept, take, pop;
  assign sel_nxt = (sel_r == LB_NUM_LANES'(NUM_LANES - 1)) ? '0 : sel_r + 1'b1;
  // rstn gates ready so no lane sees a transfer while reset is held
  assign bus.in_ready = (rstn & can_accept & !bus.clear) ? NUM_LANES'(1) << sel_r : '0;
  assign take = bus.in_valid[sel_r] & bus.in_ready[sel_r];
  assign pop = valid_r & bus.out_ready;
  assign bus.out_data = data_r;
  assign bus.out_lane = lane_r;
  assign bus.out_valid = valid_r;
  assign bus.lane_sel = sel_r;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sel_r <= '0;
    else if (bus.clear) sel_r <= '0;
    else if (take) sel_r <= sel_nxt;
`ifdef INTERLEAVE_MERGER_SKID_EN
  logic [1:0]              fill_r, wr_idx;
  logic [DATA_WIDTH-1:0]   data1_r;
  logic [LB_NUM_LANES-1:0] lane1_r;
  assign can_accept = !fill_r[1];
  assign valid_r = |fill_r;
  // slot the new word lands in, after any same-cycle pop has shifted the buffer
  assign wr_idx = fill_r - 2'(pop);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      fill_r <= '0;
      data_r <= '0;
      lane_r <= '0;
      data1_r <= '0;
      lane1_r <= '0;
    end else if (bus.clear) fill_r <= '0;
    else begin
      fill_r <= fill_r + 2'(take) - 2'(pop);
      if (pop) begin
        data_r <= data1_r;
        lane_r <= lane1_r;
      end
      if (take && wr_idx == 2'd0) begin
        data_r <= bus.in_data[sel_r];
        lane_r <= sel_r;
      end
      if (take && wr_idx == 2'd1) begin
        data1_r <= bus.in_data[sel_r];
        lane1_r <= sel_r;
      end
    end
`else
  assign can_accept = !valid_r | bus.out_ready;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      valid_r <= 1'b0;
      data_r <= '0;
      lane_r <= '0;
    end else if (bus.clear) valid_r <= 1'b0;
    else if (take) begin
      valid_r <= 1'b1;
      data_r <= bus.in_data[sel_r];
      lane_r <= sel_r;
    end else if (pop) valid_r <= 1'b0;
`endif
endmodule

// File: tb/tb_interleave_merger.sv
// tb_interleave_merger: queue-model check of interleave_merger plus directed literal checks
module tb_interleave_merger;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LB = 2;
  logic clk = 0;
  logic rstn = 0;
  logic force_a5 = 0;
  int cnt[N];
  int total = 0;
  int bad = 0;
  logic [15:0] obs[$];
  always #5 clk = ~clk;
  interleave_merger_if #(.DATA_WIDTH(W), .NUM_LANES(N)) b4();
  interleave_merger_if #(.DATA_WIDTH(W), .NUM_LANES(3)) b3();
  interleave_merger #(.DATA_WIDTH(W), .NUM_LANES(N)) dut4 (.clk(clk), .rstn(rstn), .bus(b4));
  interleave_merger #(.DATA_WIDTH(W), .NUM_LANES(3)) dut3 (.clk(clk), .rstn(rstn), .bus(b3));
  always_comb
    for (int i = 0; i < N; i++)
      b4.in_data[i] = force_a5 ? 8'hA5 : 8'(16 * i) + 8'(cnt[i] & 15);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin : model
    logic [LB+W-1:0] q[$];
    logic [LB+W-1:0] w;
    logic [LB-1:0] ptr;
    logic [N-1:0] er;
    bit tk, pp, clr, can;
    ptr = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        q.delete();
        ptr = 0;
        foreach (cnt[i]) cnt[i] = 0;
      end
`ifdef INTERLEAVE_MERGER_SKID_EN
      can = q.size() < 2;
`else
      can = q.size() == 0 || b4.out_ready;
`endif
      tk = rstn && can && !b4.clear && b4.in_valid[ptr];
      pp = rstn && !b4.clear && q.size() != 0 && b4.out_ready;
      clr = rstn && b4.clear;
      w = {ptr, b4.in_data[ptr]};
      er = (rstn && can && !b4.clear) ? N'(1) << ptr : '0;
      chk("in_ready", 32'(b4.in_ready), 32'(er));
      chk("lane_sel", 32'(b4.lane_sel), 32'(ptr));
      chk("out_valid", 32'(b4.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("out_word", 32'({b4.out_lane, b4.out_data}), 32'(q[0]));
      if (rstn && b4.out_valid && b4.out_ready) obs.push_back(16'({b4.out_lane, b4.out_data}));
      @(posedge clk);
      #1;
      if (rstn) begin
        if (clr) begin
          q.delete();
          ptr = 0;
        end else begin
          if (pp) void'(q.pop_front());
          if (tk) begin
            q.push_back(w);
            cnt[ptr]++;
            ptr = (ptr == LB'(N - 1)) ? '0 : ptr + 1'b1;
          end
        end
      end
    end
  end
  initial begin : stim
    int s;
    int seq3[7] = '{1, 2, 0, 1, 2, 0, 1};
    b4.in_valid = '1; b4.out_ready = 1; b4.clear = 0;
    b3.in_valid = '0; b3.out_ready = 1; b3.clear = 0; b3.in_data = '0;
    cyc(2);
    chk("rst_out_valid", 32'(b4.out_valid), 0);
    chk("rst_out_data", 32'(b4.out_data), 0);
    chk("rst_out_lane", 32'(b4.out_lane), 0);
    chk("rst_lane_sel", 32'(b4.lane_sel), 0);
    chk("rst_in_ready", 32'(b4.in_ready), 0);
    b4.in_valid = '0;
    @(posedge clk); #2 rstn = 1;
    cyc(1);
    b3.in_valid = '1;
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      chk("wrap3_sel", 32'(b3.lane_sel), 32'(seq3[k]));
      chk("wrap3_lane_lt3", 32'(b3.out_lane < 2'd3), 1);
    end
    b3.in_valid = '0;
    obs.delete();
    b4.in_valid = '1;
    cyc(12);
    chk("rr_count", obs.size(), 11);
    for (int k = 0; k < 8 && k < obs.size(); k++)
      chk("rr_seq", 32'(obs[k]), 32'((k % 4) * 256 + 16 * (k % 4) + k / 4));
    b4.in_valid = 4'b1101;
    cyc(1);
    chk("hol_sel", 32'(b4.lane_sel), 1);
    repeat (5) begin
      cyc(1);
      chk("hol_sel_stall", 32'(b4.lane_sel), 1);
      chk("hol_no_out", 32'(b4.out_valid), 0);
    end
    b4.in_valid = '1;
    cyc(2);
    b4.in_valid = '0;
    cyc(2);
    force_a5 = 1; b4.in_valid = '1; b4.out_ready = 0;
    cyc(1);
    s = int'(b4.lane_sel);
    repeat (3) begin
      cyc(1);
      chk("bp_data", 32'(b4.out_data), 32'h0A5);
      chk("bp_valid", 32'(b4.out_valid), 1);
`ifdef INTERLEAVE_MERGER_SKID_EN
      chk("bp_sel", 32'(b4.lane_sel), 32'((s + 1) % N));
`else
      chk("bp_sel", 32'(b4.lane_sel), 32'(s));
`endif
    end
    b4.out_ready = 1; force_a5 = 0; b4.in_valid = '0;
    cyc(3);
    b4.in_valid = '1;
    for (int k = 0; k < 8 && b4.lane_sel != 2'd1; k++) cyc(1);
    b4.in_valid = '0;
    cyc(1);
    b4.out_ready = 0; b4.in_valid = '1;
    cyc(1);
    b4.clear = 1;
    #1;
    chk("clr_in_ready", 32'(b4.in_ready), 0);
    chk("clr_valid_held", 32'(b4.out_valid), 1);
    chk("clr_sel_before", 32'(b4.lane_sel), 2);
    cyc(1);
    b4.clear = 0; b4.in_valid = '0; b4.out_ready = 1;
    chk("clr_valid_after", 32'(b4.out_valid), 0);
    chk("clr_sel_after", 32'(b4.lane_sel), 0);
    obs.delete();
    cyc(3);
    chk("clr_no_emit", obs.size(), 0);
    repeat (400) begin
      b4.in_valid = N'($urandom);
      b4.out_ready = $urandom_range(0, 3) != 0;
      b4.clear = $urandom_range(0, 30) == 0;
      cyc(1);
    end
    b4.clear = 0; b4.in_valid = '1; b4.out_ready = 1;
    cyc(3);
    @(posedge clk); #3 rstn = 0;
    #1;
    chk("arst_out_valid", 32'(b4.out_valid), 0);
    chk("arst_lane_sel", 32'(b4.lane_sel), 0);
    chk("arst_in_ready", 32'(b4.in_ready), 0);
    @(posedge clk); #2 rstn = 1;
    obs.delete();
    cyc(2);
    chk("arst_first_cnt", 32'(obs.size() >= 1), 1);
    if (obs.size() >= 1) chk("arst_first_word", 32'(obs[0]), 0);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
